// File: rtl/oport_wrra_arbiter.sv
// Weighted round-robin output-port arbiter; one-hot grant, wormhole lock.
// Optional macro WRRA_STARVE_GUARD_EN enables a starvation wait counter.
//
// Ports:
//   clk, reset           clock, async active-high reset
//   request[N]           input i has a flit for this output
//   tail_in[N]           head flit of input i is a tail
//   weight_all[N*W]      weight of input i at [(i+1)*W-1 : i*W]
//   oport_ready          downstream credit available this cycle
//   grant[N]             combinational one-hot flit transfer
//   any_grant            OR of grant
//   owner[N]             registered current owner (0 in IDLE)
//   weight_is_consumed   one-cycle pulse after a budget-exhausting tail
module oport_wrra_arbiter #(
    parameter int N       = 4,
    parameter int WEIGHTw = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         request,
    input  logic [N-1:0]         tail_in,
    input  logic [N*WEIGHTw-1:0] weight_all,
    input  logic                 oport_ready,
    output logic [N-1:0]         grant,
    output logic                 any_grant,
    output logic [N-1:0]         owner,
    output logic                 weight_is_consumed
);

    typedef enum logic {IDLE, SERVE} state_t;

    localparam logic [N-1:0]       ONE_N = N'(1);
    localparam logic [WEIGHTw-1:0] ONE_W = WEIGHTw'(1);

    state_t           state_q, state_d;
    logic [N-1:0]     ptr_q, ptr_d;
    logic [N-1:0]     owner_q, owner_d;
    logic [WEIGHTw-1:0] budget_q, budget_d;
    logic             locked_q, locked_d;
    logic             wic_q, wic_d;

    logic [N-1:0]     grant_c;
    logic [N-1:0]     req_hi;
    logic [N-1:0]     rr_gnt;
    logic [WEIGHTw-1:0] wsel;
    logic [WEIGHTw-1:0] w_eff;
    logic             own_tail;
    logic             own_req;
    logic             starve;

    // Bits at or above ptr get first pick; lowest set bit wins,
    // falling back to the whole vector for the wrap-around.
    always_comb begin
        req_hi = request & ~(ptr_q - ONE_N);
        if (|req_hi) begin
            rr_gnt = req_hi & (~req_hi + ONE_N);
        end else begin
            rr_gnt = request & (~request + ONE_N);
        end
    end

    always_comb begin
        wsel = '0;
        for (int i = 0; i < N; i++) begin
            if (rr_gnt[i]) begin
                wsel = wsel | weight_all[i*WEIGHTw +: WEIGHTw];
            end
        end
        w_eff = (wsel == '0) ? ONE_W : wsel;
    end

    assign own_tail = |(owner_q & tail_in);
    assign own_req  = |(owner_q & request);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        budget_d = budget_q;
        locked_d = locked_q;
        wic_d    = 1'b0;
        grant_c  = '0;
        unique case (state_q)
            IDLE: begin
                grant_c = oport_ready ? rr_gnt : '0;
                if (|grant_c) begin
                    locked_d = ~|(grant_c & tail_in);
                    budget_d = w_eff - ONE_W;
                    if ((|(grant_c & tail_in)) && w_eff == ONE_W) begin
                        owner_d = '0;
                        ptr_d   = {grant_c[N-2:0], grant_c[N-1]};
                        wic_d   = 1'b1;
                    end else begin
                        owner_d = grant_c;
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                grant_c = owner_q & request & {N{oport_ready}};
                if (|grant_c) begin
                    budget_d = (budget_q == '0) ? '0 : budget_q - ONE_W;
                    locked_d = ~own_tail;
                    // Budget only ends service on a packet boundary.
                    if (own_tail && (budget_q <= ONE_W || starve)) begin
                        state_d  = IDLE;
                        owner_d  = '0;
                        budget_d = '0;
                        ptr_d    = {owner_q[N-2:0], owner_q[N-1]};
                        wic_d    = 1'b1;
                    end
                end else if (!own_req && !locked_q) begin
                    // Owner went quiet between packets: forfeit budget.
                    state_d  = IDLE;
                    owner_d  = '0;
                    budget_d = '0;
                    ptr_d    = {owner_q[N-2:0], owner_q[N-1]};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant     = reset ? '0 : grant_c;
    assign any_grant = |grant;

`ifdef WRRA_STARVE_GUARD_EN
    logic [5:0] wait_q, wait_d;
    logic       rot;
    logic       inc;

    assign starve = (wait_q == 6'd63);
    assign rot    = wic_d || (state_q == SERVE && state_d == IDLE);
    assign inc    = (|(request & ~owner_q)) && (|(grant_c & owner_q));

    always_comb begin
        wait_d = wait_q;
        if (rot) begin
            wait_d = '0;
        end else if (inc && !starve) begin
            wait_d = wait_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= ONE_N;
            owner_q  <= '0;
            budget_q <= '0;
            locked_q <= 1'b0;
            wic_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            budget_q <= budget_d;
            locked_q <= locked_d;
            wic_q    <= wic_d;
        end
    end

    assign owner              = owner_q;
    assign weight_is_consumed = wic_q;

endmodule

// File: tb/tb_oport_wrra_arbiter.sv
// Self-checking bench for oport_wrra_arbiter.
// Table-driven scenarios feed a scoreboard of expected outputs.
module tb_oport_wrra_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  request;
    logic [3:0]  tail_in;
    logic [15:0] weight_all;
    logic        oport_ready;
    logic [3:0]  grant;
    logic        any_grant;
    logic [3:0]  owner;
    logic        weight_is_consumed;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] tail;
        logic       rdy;
        logic [3:0] g;
        logic [3:0] o;
        logic       w;
    } row_t;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] o;
        logic       w;
    } exp_t;

    exp_t sb[$];

    oport_wrra_arbiter #(.N(4), .WEIGHTw(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .request            (request),
        .tail_in            (tail_in),
        .weight_all         (weight_all),
        .oport_ready        (oport_ready),
        .grant              (grant),
        .any_grant          (any_grant),
        .owner              (owner),
        .weight_is_consumed (weight_is_consumed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset       = 1'b1;
        request     = '0;
        tail_in     = '0;
        oport_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset       = 1'b1;
        request     = 4'b1111;
        tail_in     = 4'b1111;
        oport_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grant got=%b exp=0000", grant);
        end
        checks++;
        if (any_grant !== 1'b0) begin
            errors++;
            $display("FAIL reset_any got=%b exp=0", any_grant);
        end
        checks++;
        if (owner !== 4'b0000) begin
            errors++;
            $display("FAIL reset_owner got=%b exp=0000", owner);
        end
        checks++;
        if (weight_is_consumed !== 1'b0) begin
            errors++;
            $display("FAIL reset_wic got=%b exp=0", weight_is_consumed);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_equal();
        row_t t[5] = '{
            '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0},
            '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b0000, 1'b1},
            '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1}
        };
        exp_t e;
        do_reset();
        weight_all = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int c = 0; c < 5; c++) begin
            reset = t[c].rst; request = t[c].req;
            tail_in = t[c].tail; oport_ready = t[c].rdy;
            sb.push_back('{t[c].g, t[c].o, t[c].w});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
                errors++;
                $display("FAIL equal_grant c%0d got=%b exp=%b", c, grant, e.g);
            end
            checks++;
            if (any_grant !== (|e.g)) begin
                errors++;
                $display("FAIL equal_any c%0d got=%b exp=%b", c, any_grant, |e.g);
            end
            checks++;
            if (owner !== e.o) begin
                errors++;
                $display("FAIL equal_owner c%0d got=%b exp=%b", c, owner, e.o);
            end
            checks++;
            if (weight_is_consumed !== e.w) begin
                errors++;
                $display("FAIL equal_wic c%0d got=%b exp=%b", c, weight_is_consumed, e.w);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_weighted();
        row_t t[8] = '{
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b1},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0},
            '{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b1}
        };
        exp_t e;
        do_reset();
        weight_all = {4'd1, 4'd1, 4'd1, 4'd3};
        for (int c = 0; c < 8; c++) begin
            reset = t[c].rst; request = t[c].req;
            tail_in = t[c].tail; oport_ready = t[c].rdy;
            sb.push_back('{t[c].g, t[c].o, t[c].w});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
                errors++;
                $display("FAIL wgt_grant c%0d got=%b exp=%b", c, grant, e.g);
            end
            checks++;
            if (owner !== e.o) begin
                errors++;
                $display("FAIL wgt_owner c%0d got=%b exp=%b", c, owner, e.o);
            end
            checks++;
            if (weight_is_consumed !== e.w) begin
                errors++;
                $display("FAIL wgt_wic c%0d got=%b exp=%b", c, weight_is_consumed, e.w);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wormhole();
        row_t t[7] = '{
            '{1'b0, 4'b1010, 4'b1000, 1'b1, 4'b0010, 4'b0000, 1'b0},
            '{1'b0, 4'b1010, 4'b1000, 1'b1, 4'b0010, 4'b0010, 1'b0},
            '{1'b0, 4'b1010, 4'b1000, 1'b0, 4'b0000, 4'b0010, 1'b0},
            '{1'b0, 4'b1010, 4'b1000, 1'b1, 4'b0010, 4'b0010, 1'b0},
            '{1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b0},
            '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1}
        };
        exp_t e;
        do_reset();
        weight_all = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int c = 0; c < 7; c++) begin
            reset = t[c].rst; request = t[c].req;
            tail_in = t[c].tail; oport_ready = t[c].rdy;
            sb.push_back('{t[c].g, t[c].o, t[c].w});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
                errors++;
                $display("FAIL worm_grant c%0d got=%b exp=%b", c, grant, e.g);
            end
            checks++;
            if (any_grant !== (|e.g)) begin
                errors++;
                $display("FAIL worm_any c%0d got=%b exp=%b", c, any_grant, |e.g);
            end
            checks++;
            if (owner !== e.o) begin
                errors++;
                $display("FAIL worm_owner c%0d got=%b exp=%b", c, owner, e.o);
            end
            checks++;
            if (weight_is_consumed !== e.w) begin
                errors++;
                $display("FAIL worm_wic c%0d got=%b exp=%b", c, weight_is_consumed, e.w);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_weight();
        row_t t[4] = '{
            '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0},
            '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1},
            '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1},
            '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1}
        };
        exp_t e;
        do_reset();
        weight_all = {4'd1, 4'd0, 4'd1, 4'd1};
        for (int c = 0; c < 4; c++) begin
            reset = t[c].rst; request = t[c].req;
            tail_in = t[c].tail; oport_ready = t[c].rdy;
            sb.push_back('{t[c].g, t[c].o, t[c].w});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
                errors++;
                $display("FAIL zero_grant c%0d got=%b exp=%b", c, grant, e.g);
            end
            checks++;
            if (owner !== e.o) begin
                errors++;
                $display("FAIL zero_owner c%0d got=%b exp=%b", c, owner, e.o);
            end
            checks++;
            if (weight_is_consumed !== e.w) begin
                errors++;
                $display("FAIL zero_wic c%0d got=%b exp=%b", c, weight_is_consumed, e.w);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_drop();
        row_t t[5] = '{
            '{1'b0, 4'b0011, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0},
            '{1'b0, 4'b0011, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0},
            '{1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0},
            '{1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0010, 4'b0000, 1'b0},
            '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1}
        };
        exp_t e;
        do_reset();
        weight_all = {4'd1, 4'd1, 4'd1, 4'd5};
        for (int c = 0; c < 5; c++) begin
            reset = t[c].rst; request = t[c].req;
            tail_in = t[c].tail; oport_ready = t[c].rdy;
            sb.push_back('{t[c].g, t[c].o, t[c].w});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
                errors++;
                $display("FAIL drop_grant c%0d got=%b exp=%b", c, grant, e.g);
            end
            checks++;
            if (owner !== e.o) begin
                errors++;
                $display("FAIL drop_owner c%0d got=%b exp=%b", c, owner, e.o);
            end
            checks++;
            if (weight_is_consumed !== e.w) begin
                errors++;
                $display("FAIL drop_wic c%0d got=%b exp=%b", c, weight_is_consumed, e.w);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        row_t t[5] = '{
            '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b0},
            '{1'b0, 4'b1001, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b0},
            '{1'b1, 4'b1001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0},
            '{1'b0, 4'b1001, 4'b1001, 1'b1, 4'b0001, 4'b0000, 1'b0},
            '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1}
        };
        exp_t e;
        do_reset();
        weight_all = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int c = 0; c < 5; c++) begin
            reset = t[c].rst; request = t[c].req;
            tail_in = t[c].tail; oport_ready = t[c].rdy;
            sb.push_back('{t[c].g, t[c].o, t[c].w});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g) begin
                errors++;
                $display("FAIL rmid_grant c%0d got=%b exp=%b", c, grant, e.g);
            end
            checks++;
            if (owner !== e.o) begin
                errors++;
                $display("FAIL rmid_owner c%0d got=%b exp=%b", c, owner, e.o);
            end
            checks++;
            if (weight_is_consumed !== e.w) begin
                errors++;
                $display("FAIL rmid_wic c%0d got=%b exp=%b", c, weight_is_consumed, e.w);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        request     = '0;
        tail_in     = '0;
        weight_all  = '0;
        oport_ready = 1'b0;
        test_reset();
        test_equal();
        test_weighted();
        test_wormhole();
        test_zero_weight();
        test_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oport_wrra_arbiter.md
Name: oport_wrra_arbiter

Overview:
- Per-output-port weighted round-robin switch arbiter, one instance per router output port.
- Shares one crossbar output among N input ports.
- Each winning input gets a flit budget equal to its weight, and wormhole packets are never interleaved.
- Produces the one-hot grant that drives the crossbar select and the weight-consumed indication used by the weight-update logic.

Parameters:
- N, 4, number of requesting input ports (P-1 for a 5-port mesh router)
- WEIGHTw, 4, width of each per-requester weight and of the budget counter

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- request  input  N  input port i has a flit for this output port
- tail_in  input  N  head-of-queue flit of input i is a tail (single-flit packet = tail)
- weight_all  input  N*WEIGHTw  weight of input i at bits [(i+1)*WEIGHTw-1 : i*WEIGHTw]
- oport_ready  input  1  downstream VC has credit; a flit may cross this cycle
- grant  output  N  one-hot grant, combinational; a grant is a flit transfer
- any_grant  output  1  OR of grant
- owner  output  N  registered one-hot current owner; 0 in IDLE
- weight_is_consumed  output  1  registered one-cycle pulse when an owner's budget is exhausted at a packet boundary

Behaviour:
- Reset (async):
  - state=IDLE, ptr=one-hot bit0, owner=0, budget=0, locked=0, weight_is_consumed=0.
  - grant and any_grant evaluate to 0 while reset is high.
- grant is never asserted while oport_ready=0. State holds when there is no transfer.
- Effective weight: w_eff = (weight==0) ? 1 : weight. It is sampled only when ownership starts; changes during service are ignored.
- IDLE:
  - grant = first set bit of request, searching from ptr upward with wrap. Qualified by oport_ready.
  - On transfer by input g: owner<=g, budget<=w_eff-1, locked<=~tail_in[g].
  - If tail_in[g] && w_eff==1: stay IDLE, owner<=0, ptr<=rotate-left(g), weight_is_consumed<=1. Otherwise go to SERVE.
- SERVE:
  - grant = owner & request & oport_ready.
  - On transfer: budget<=budget-1, saturating at 0; locked<=~tail_in[owner].
  - Tail transferred and budget before decrement <=1: go to IDLE, owner<=0, ptr<=rotate-left(owner), weight_is_consumed<=1.
  - Tail transferred with budget remaining: stay SERVE. The next packet from the same owner is granted with no bubble.
  - request[owner]=0 while locked=0: go to IDLE, owner<=0, ptr<=rotate-left(owner), budget<=0. The remaining budget is forfeited and weight_is_consumed is not pulsed.
  - request[owner]=0 while locked=1: hold SERVE with no grant. Other requesters are blocked until the tail crosses.
  - Non-tail flit with budget 0: stay locked and continue. The budget never splits a packet.
- weight_is_consumed is high for exactly one cycle after the rotating transfer.
- Latency: the grant is same-cycle combinational. Ownership and pointer update on the next clk edge.
- Simultaneous events: an oport_ready drop and a request change in the same cycle are treated as no transfer; only request-loss rules apply.
- Reset asserted mid-packet aborts the lock immediately.

Optional Feature:
- Macro: WRRA_STARVE_GUARD_EN
- When defined:
  - Adds a 6-bit wait counter, cleared by reset.
  - It increments each cycle in which any non-owner request is high and the owner gets a grant. It clears on rotation.
  - When it reaches 63, the owner's budget is forced to 0 at the next tail transfer. This causes rotation and a weight_is_consumed pulse.
  - Lock semantics are unchanged.
- When undefined: no counter exists, and budgets are honoured fully.

Test Plan:
- N=4, weights {1,1,1,1}, request=4'b1111, all flits tail, oport_ready=1 -> grant sequence 0001,0010,0100,1000,0001. weight_is_consumed=1 every cycle after the first.
- weights in0=3, in2=1; request=4'b0101; all tails -> grants in0,in0,in0,in2,in0,in0,in0,in2.
- in1 sends a 4-flit packet (tail on 4th) with weight 1 while in3 requests; oport_ready=0 on cycle 2 -> in1 granted 4 times, no grant on the stalled cycle, in3 granted only after the tail.
- weight 0 on in2, only in2 requesting single-flit packets -> grant every cycle, with a weight_is_consumed pulse each cycle (w_eff=1).
- in0 weight 5 owns; after 2 tails in0 drops request with in1 requesting -> IDLE, in1 granted next cycle, no weight_is_consumed pulse.
- Reset asserted mid-packet while in3 is locked -> next cycle owner=0, ptr=bit0. With request=4'b1001, in0 is granted.
